// File: rtl/tx_source_switch_ctrl.sv
// Switch synchronise/debounce, registered source select and TX PLL reset/lock
// sequencing with bounded retries for the HDMI pass-through clocking.
module tx_source_switch_ctrl #(
    parameter int N_SW            = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int RST_HOLD        = 16,
    parameter int LOCK_TIMEOUT    = 2500000,
    parameter int TO_W            = 22,
    parameter int MAX_RETRY       = 3
) (
    input  logic            clk25,
    input  logic            rstin,
    input  logic [N_SW-1:0] sw_async,
    input  logic            pll_locked,
    output logic [N_SW-1:0] sel,
    output logic            sel_change,
    output logic            pll_reset,
    output logic            tx_ready,
    output logic            lock_fail,
    output logic [1:0]      state_dbg
);

    localparam logic [1:0] ST_RESET_PLL = 2'b00;
    localparam logic [1:0] ST_WAIT_LOCK = 2'b01;
    localparam logic [1:0] ST_RUN       = 2'b10;
    localparam logic [1:0] ST_FAIL      = 2'b11;

    localparam int HOLD_W  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
    localparam logic [2:0]         LOCK_QUAL = 3'd3;

    logic [N_SW-1:0]            sw_meta_q, sw_sync_q;
    logic                       lock_meta_q, lock_sync_q;
    logic [N_SW-1:0]            stable_q, stable_d;
    logic [N_SW-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_SW-1:0]            sel_q, sel_d;
    logic                       sel_change_q, sel_change_d;
    logic [1:0]                 state_q, state_d;
    logic [HOLD_W-1:0]          hold_q, hold_d;
    logic [TO_W-1:0]            to_q, to_d;
    logic [RETRY_W-1:0]         retry_q, retry_d, retry_next;
    logic [2:0]                 lock_cnt_q, lock_cnt_d;

    // Per-bit debounce: accept a new level only after DEBOUNCE_CYCLES of disagreement.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < N_SW; i++) begin
            if (sw_sync_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= DB_LAST) begin
                stable_d[i] = sw_sync_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        sel_change_d = 1'b0;
        hold_d       = hold_q;
        to_d         = to_q;
        retry_d      = retry_q;
        lock_cnt_d   = '0;
        retry_next   = (retry_q >= RETRY_LIM) ? retry_q : retry_q + 1'b1;

        // A new select always restarts PLL sequencing, whatever the current state.
        if (stable_q != sel_q) begin
            sel_d        = stable_q;
            sel_change_d = 1'b1;
            state_d      = ST_RESET_PLL;
            hold_d       = '0;
            to_d         = '0;
            retry_d      = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    to_d = '0;
                    if (hold_q >= HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    hold_d = '0;
                    if (lock_sync_q) begin
                        lock_cnt_d = (lock_cnt_q >= LOCK_QUAL) ? lock_cnt_q : lock_cnt_q + 1'b1;
                    end
                    // Lock qualification beats a coincident timeout.
                    if (lock_sync_q && (lock_cnt_q >= LOCK_QUAL)) begin
                        state_d = ST_RUN;
                        to_d    = '0;
                    end else if (to_q >= TO_LAST) begin
                        to_d    = '0;
                        retry_d = retry_next;
                        state_d = (retry_next < RETRY_LIM) ? ST_RESET_PLL : ST_FAIL;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    hold_d  = '0;
                    retry_d = '0;
                    if (!lock_sync_q) begin
                        state_d = ST_RESET_PLL;
                    end
                end
                ST_FAIL: begin
                    hold_d = '0;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk25 or posedge rstin) begin
        if (rstin) begin
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            stable_q     <= '0;
            cnt_q        <= '0;
            sel_q        <= '0;
            sel_change_q <= 1'b0;
            state_q      <= ST_RESET_PLL;
            hold_q       <= '0;
            to_q         <= '0;
            retry_q      <= '0;
            lock_cnt_q   <= '0;
        end else begin
            sw_meta_q    <= sw_async;
            sw_sync_q    <= sw_meta_q;
            lock_meta_q  <= pll_locked;
            lock_sync_q  <= lock_meta_q;
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            sel_change_q <= sel_change_d;
            state_q      <= state_d;
            hold_q       <= hold_d;
            to_q         <= to_d;
            retry_q      <= retry_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    assign sel        = sel_q;
    assign sel_change = sel_change_q;
    assign pll_reset  = (state_q == ST_RESET_PLL);
    assign tx_ready   = (state_q == ST_RUN);
    assign lock_fail  = (state_q == ST_FAIL);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_tx_source_switch_ctrl.sv
// Bench for tx_source_switch_ctrl: reset/lock, debounce, timeout/fail, lock loss,
// simultaneous and mid-reset select changes, asynchronous reset mid-operation.
module tb_tx_source_switch_ctrl;

    logic       clk25;
    logic       rstin;
    logic [1:0] sw_async;
    logic       pll_locked;
    logic [1:0] sel;
    logic       sel_change;
    logic       pll_reset;
    logic       tx_ready;
    logic       lock_fail;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];

    tx_source_switch_ctrl #(
        .N_SW(2), .DEBOUNCE_CYCLES(8), .CNT_W(4), .RST_HOLD(4),
        .LOCK_TIMEOUT(32), .TO_W(6), .MAX_RETRY(2)
    ) dut (
        .clk25(clk25), .rstin(rstin), .sw_async(sw_async), .pll_locked(pll_locked),
        .sel(sel), .sel_change(sel_change), .pll_reset(pll_reset), .tx_ready(tx_ready),
        .lock_fail(lock_fail), .state_dbg(state_dbg)
    );

    // clock/reset block
    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!tx_ready && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, 32'(tx_ready), 32'd1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard: every sel_change pulse consumes one expected select word
    always @(negedge clk25) begin
        logic [1:0] e;
        if (!rstin && sel_change) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected_pulse", 32'(sel_change), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("sb_sel", 32'(sel), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstin      = 1'b1;
        sw_async   = 2'b00;
        pll_locked = 1'b0;

        // 1. reset and lock
        repeat (5) @(posedge clk25);
        #1;
        check_val("rst_state", 32'(state_dbg), 32'd0);
        check_val("rst_pll_reset", 32'(pll_reset), 32'd1);
        check_val("rst_sel", 32'(sel), 32'd0);
        check_val("rst_sel_change", 32'(sel_change), 32'd0);
        check_val("rst_tx_ready", 32'(tx_ready), 32'd0);
        check_val("rst_lock_fail", 32'(lock_fail), 32'd0);
        rstin = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_val("t1_pll_reset_hold", 32'(pll_reset), 32'd1);
            tick();
        end
        check_val("t1_pll_reset_drop", 32'(pll_reset), 32'd0);
        check_val("t1_wait_lock", 32'(state_dbg), 32'd1);
        repeat (6) tick();
        pll_locked = 1'b1;
        repeat (7) tick();
        check_val("t1_tx_ready", 32'(tx_ready), 32'd1);
        check_val("t1_sel", 32'(sel), 32'd0);

        // 2. debounce: bouncing input rejected, then a clean level accepted
        for (int seg = 0; seg < 10; seg++) begin
            sw_async[0] = (seg % 2 == 0);
            repeat (3) tick();
        end
        check_val("t2_bounce_sel", 32'(sel), 32'd0);
        sw_async[0] = 1'b1;
        exp_q.push_back(2'b01);
        repeat (10) tick();
        check_val("t2_sel_before", 32'(sel), 32'd0);
        tick();
        check_val("t2_sel_after", 32'(sel), 32'd1);
        check_val("t2_sel_change", 32'(sel_change), 32'd1);
        check_val("t2_pll_reset_0", 32'(pll_reset), 32'd1);
        tick();
        check_val("t2_sel_change_end", 32'(sel_change), 32'd0);
        repeat (2) tick();
        check_val("t2_pll_reset_3", 32'(pll_reset), 32'd1);
        tick();
        check_val("t2_pll_reset_4", 32'(pll_reset), 32'd0);
        wait_ready("t2_relock", 20);

        // 3. timeout and fail: lock-loss restart, then two timed-out attempts
        pll_locked = 1'b0;
        repeat (2) tick();
        check_val("t3_tx_ready_hold", 32'(tx_ready), 32'd1);
        tick();
        check_val("t3_reset_a", 32'(state_dbg), 32'd0);
        repeat (3) tick();
        check_val("t3_reset_a_end", 32'(pll_reset), 32'd1);
        tick();
        check_val("t3_wait_a", 32'(state_dbg), 32'd1);
        repeat (31) tick();
        check_val("t3_wait_a_end", 32'(state_dbg), 32'd1);
        tick();
        check_val("t3_reset_b", 32'(state_dbg), 32'd0);
        repeat (3) tick();
        check_val("t3_reset_b_end", 32'(state_dbg), 32'd0);
        tick();
        check_val("t3_wait_b", 32'(state_dbg), 32'd1);
        repeat (31) tick();
        check_val("t3_wait_b_end", 32'(state_dbg), 32'd1);
        tick();
        check_val("t3_fail_state", 32'(state_dbg), 32'd3);
        check_val("t3_lock_fail", 32'(lock_fail), 32'd1);
        check_val("t3_fail_pll_reset", 32'(pll_reset), 32'd0);
        check_val("t3_fail_tx_ready", 32'(tx_ready), 32'd0);
        repeat (5) tick();
        check_val("t3_fail_sticky", 32'(state_dbg), 32'd3);
        sw_async[0] = 1'b0;
        exp_q.push_back(2'b00);
        repeat (10) tick();
        check_val("t3_fail_before_chg", 32'(lock_fail), 32'd1);
        tick();
        check_val("t3_fail_exit_flag", 32'(lock_fail), 32'd0);
        check_val("t3_fail_exit_state", 32'(state_dbg), 32'd0);
        pll_locked = 1'b1;
        wait_ready("t3_relock", 40);

        // 4. single-cycle lock loss in RUN
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        check_val("t4_tx_ready_hold", 32'(tx_ready), 32'd1);
        tick();
        check_val("t4_tx_ready_drop", 32'(tx_ready), 32'd0);
        check_val("t4_reset_state", 32'(state_dbg), 32'd0);
        repeat (3) tick();
        check_val("t4_reset_end", 32'(pll_reset), 32'd1);
        tick();
        check_val("t4_wait", 32'(state_dbg), 32'd1);
        repeat (3) tick();
        check_val("t4_not_yet_run", 32'(tx_ready), 32'd0);
        tick();
        check_val("t4_run", 32'(state_dbg), 32'd2);

        // 5a. both bits together: one pulse, 00 -> 11
        sw_async = 2'b11;
        exp_q.push_back(2'b11);
        repeat (10) tick();
        check_val("t5_sel_before", 32'(sel), 32'd0);
        tick();
        check_val("t5_sel_after", 32'(sel), 32'd3);
        check_val("t5_sel_change", 32'(sel_change), 32'd1);
        tick();
        check_val("t5_sel_change_end", 32'(sel_change), 32'd0);
        wait_ready("t5_relock", 20);

        // 5b. second change lands on cycle 2 of the reset hold
        sw_async[0] = 1'b0;
        exp_q.push_back(2'b10);
        repeat (2) tick();
        sw_async[1] = 1'b0;
        exp_q.push_back(2'b00);
        repeat (9) tick();
        check_val("t5b_first_sel", 32'(sel), 32'd2);
        check_val("t5b_first_reset", 32'(pll_reset), 32'd1);
        repeat (2) tick();
        check_val("t5b_second_sel", 32'(sel), 32'd0);
        check_val("t5b_second_pulse", 32'(sel_change), 32'd1);
        repeat (3) tick();
        check_val("t5b_hold_restart", 32'(pll_reset), 32'd1);
        tick();
        check_val("t5b_hold_done", 32'(state_dbg), 32'd1);
        tick();

        // 6. asynchronous reset during WAIT_LOCK
        rstin = 1'b1;
        #1;
        check_val("t6_wait_state", 32'(state_dbg), 32'd0);
        check_val("t6_wait_pll_reset", 32'(pll_reset), 32'd1);
        check_val("t6_wait_tx_ready", 32'(tx_ready), 32'd0);
        repeat (2) tick();
        rstin = 1'b0;
        wait_ready("t6_relock", 40);
        sw_async = 2'b10;
        exp_q.push_back(2'b10);
        wait_drain("t6_sel_10", 30);
        wait_ready("t6_run_again", 30);

        // asynchronous reset during RUN with a non-zero select
        rstin = 1'b1;
        #1;
        check_val("t6_run_sel", 32'(sel), 32'd0);
        check_val("t6_run_tx_ready", 32'(tx_ready), 32'd0);
        check_val("t6_run_pll_reset", 32'(pll_reset), 32'd1);
        check_val("t6_run_state", 32'(state_dbg), 32'd0);
        check_val("t6_run_lock_fail", 32'(lock_fail), 32'd0);
        exp_q.push_back(2'b10);
        repeat (2) tick();
        rstin = 1'b0;
        wait_drain("t6_reacquire", 30);
        check_val("t6_final_sel", 32'(sel), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
